// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle controller: opcodes, FSM states,
// ALU operations, PC/writeback selects and the illegal-encoding classifier.
package rv32_ctrl_pkg;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SLL    = 4'b0001;
  localparam logic [3:0] ALU_SLT    = 4'b0010;
  localparam logic [3:0] ALU_SLTU   = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SRL    = 4'b0101;
  localparam logic [3:0] ALU_OR     = 4'b0110;
  localparam logic [3:0] ALU_AND    = 4'b0111;
  localparam logic [3:0] ALU_SUB    = 4'b1000;
  localparam logic [3:0] ALU_SRA    = 4'b1101;
  localparam logic [3:0] ALU_PASS_B = 4'b1111;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  function automatic logic is_illegal(input logic [4:0] opc, input logic [2:0] f3,
                                      input logic f7);
    logic ill;
    ill = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_MISC_MEM, OPC_SYSTEM: ill = 1'b0;
      OPC_JALR:   ill = (f3 != 3'b000);
      OPC_BRANCH: ill = (f3 == 3'b010) || (f3 == 3'b011);
      OPC_LOAD:   ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      OPC_STORE:  ill = (f3 >= 3'b011);
      OPC_OP:     ill = f7 && (f3 != 3'b000) && (f3 != 3'b101);
      OPC_OP_IMM: ill = f7 && (f3 == 3'b001);
      default:    ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/rv32_alu_op_dec.sv
// Maps instruction fields to the ALU operation; func7 only matters for OP
// and for the OP-IMM shift-right pair (SRLI/SRAI).
module rv32_alu_op_dec
  import rv32_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic [2:0] func3,
  input  logic       func7,
  output logic [3:0] alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (opcode)
      OPC_OP:     alu_op = {func7, func3};
      OPC_OP_IMM: alu_op = {(func3 == 3'b101) ? func7 : 1'b0, func3};
      OPC_LUI:    alu_op = ALU_PASS_B;
      default:    alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the shared RV32I datapath.
// The IR holds the instruction from DECODE onward, so opcode fields are used live.
module rv32_multicycle_ctrl
  import rv32_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] opcode,
  input  logic [2:0] func3,
  input  logic       func7,
  input  logic       branch_cond,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic [3:0] alu_op,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       halt,
  output logic       illegal
);

  state_t     state_reg, state_next;
  logic       illegal_reg;
  logic       dec_illegal;
  logic [3:0] dec_alu_op;

  assign dec_illegal = is_illegal(opcode, func3, func7);

  rv32_alu_op_dec u_alu_op_dec (
    .opcode (opcode),
    .func3  (func3),
    .func7  (func7),
    .alu_op (dec_alu_op)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_FETCH;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_DECODE && dec_illegal) illegal_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next   = state_reg;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_PLUS4;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = ALU_ADD;
    rf_we        = 1'b0;
    wb_sel       = WB_ALU;
    retire       = 1'b0;
    halt         = 1'b0;
    illegal      = 1'b0;

    case (state_reg)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we      = 1'b1;
          state_next = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (dec_illegal || opcode == OPC_SYSTEM) begin
          halt       = 1'b1;
          illegal    = dec_illegal;
          state_next = ST_HALT;
        end else begin
          state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        alu_op = dec_alu_op;
        case (opcode)
          OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_JALR: alu_src_b = 1'b1;
          OPC_AUIPC, OPC_JAL: begin
            alu_src_a = 1'b1;
            alu_src_b = 1'b1;
          end
          OPC_LUI: alu_src_b = 1'b1;
          default: ;
        endcase
        case (opcode)
          OPC_BRANCH: begin
            pc_we      = 1'b1;
            pc_sel     = branch_cond ? PC_IMM : PC_PLUS4;
            retire     = 1'b1;
            state_next = ST_FETCH;
          end
          OPC_MISC_MEM: begin
            pc_we      = 1'b1;
            retire     = 1'b1;
            state_next = ST_FETCH;
          end
          OPC_LOAD, OPC_STORE: state_next = ST_MEM;
          default:             state_next = ST_WB;
        endcase
      end

      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode == OPC_STORE);
        if (mem_ready) begin
          if (opcode == OPC_STORE) begin
            pc_we      = 1'b1;
            retire     = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end
      end

      ST_WB: begin
        rf_we  = 1'b1;
        pc_we  = 1'b1;
        retire = 1'b1;
        case (opcode)
          OPC_LOAD: wb_sel = WB_MEM;
          OPC_JAL: begin
            wb_sel = WB_PC4;
            pc_sel = PC_IMM;
          end
          OPC_JALR: begin
            wb_sel = WB_PC4;
            pc_sel = PC_ALU;
          end
          default: ;
        endcase
        state_next = ST_FETCH;
      end

      ST_HALT: begin
        halt    = 1'b1;
        illegal = illegal_reg;
      end

      default: state_next = ST_FETCH;
    endcase

    // Reset dominates: nothing reaches the datapath while rst is high.
    if (rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = PC_PLUS4;
      alu_src_a    = 1'b0;
      alu_src_b    = 1'b0;
      alu_op       = ALU_ADD;
      rf_we        = 1'b0;
      wb_sel       = WB_ALU;
      retire       = 1'b0;
      halt         = 1'b0;
      illegal      = 1'b0;
    end
  end

endmodule

// File: doc/rv32_multicycle_ctrl.md
# rv32_multicycle_ctrl

Multicycle control FSM for the RV32I core. Consumes the opcode/func3/func7 fields produced by the instruction decoder and sequences the shared datapath (PC, IR, register file, ALU, single unified memory port) through FETCH/DECODE/EXEC/MEM/WB. Drives all datapath selects and enables, runs the memory request handshake, and halts on ECALL/EBREAK or an illegal encoding.

## Interface
- No parameters; all encodings are fixed in the package.
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- opcode  in  5  instruction bits [6:2], from the IR via the decoder
- func3  in  3  instruction bits [14:12]
- func7  in  1  instruction bit 30
- branch_cond  in  1  comparator result for the current branch func3
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  store request (valid with mem_req)
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_we  out  1  load IR from memory read data
- pc_we  out  1  update PC
- pc_sel  out  2  0 = PC+4, 1 = PC+imm, 2 = ALU result & ~1
- alu_src_a  out  1  0 = rs1, 1 = PC
- alu_src_b  out  1  0 = rs2, 1 = imm
- alu_op  out  4  ALU operation
- rf_we  out  1  register file write
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4
- retire  out  1  one-cycle pulse per completed instruction
- halt  out  1  core stopped (sticky until rst)
- illegal  out  1  halt caused by an illegal encoding (sticky)

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Reset state is FETCH.
- FETCH
  - mem_req=1, mem_addr_sel=0.
  - On mem_ready: ir_we=1, go to DECODE. Otherwise stay in FETCH.
- DECODE (one cycle)
  - Classify the instruction, then go to EXEC.
  - SYSTEM (11100) goes to HALT with halt=1.
  - An illegal encoding goes to HALT with halt=1 and illegal=1.
  - Illegal encodings:
    - any opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM}
    - LOAD with func3 in {011, 110, 111}
    - STORE with func3 ≥ 011
    - BRANCH with func3 in {010, 011}
    - JALR with func3 ≠ 000
    - OP with func7=1 and func3 ∉ {000, 101}
    - OP-IMM func3=001 with func7=1
- EXEC
  - Drive the ALU operands per class:
    - OP: rs1, rs2
    - OP-IMM, LOAD, STORE, JALR: rs1, imm
    - AUIPC, JAL: PC, imm
    - LUI: PASS_B, imm
  - BRANCH: pc_we=1. pc_sel=1 if branch_cond, else 0. retire=1, go to FETCH.
  - MISC-MEM (FENCE) is a no-op: pc_we=1, pc_sel=0, retire=1, go to FETCH.
  - LOAD and STORE go to MEM. All other classes go to WB.
- MEM
  - mem_req=1, mem_addr_sel=1, mem_we=1 for STORE.
  - Wait for mem_ready.
  - STORE: pc_we=1, pc_sel=0, retire=1, go to FETCH.
  - LOAD: go to WB.
- WB
  - rf_we=1.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - pc_we=1. pc_sel: 1 for JAL, 2 for JALR, 0 otherwise.
  - retire=1, go to FETCH.
- HALT: absorbing. All enables and mem_req stay 0; only rst leaves HALT.
- alu_op:
  - OP: {func7, func3}.
  - OP-IMM: {func7 if func3=101 else 0, func3}.
  - LUI: PASS_B.
  - All others: ADD.
- Outputs are combinational from state and inputs. Signals not listed for a state are 0.

## Timing
- While rst=1:
  - Every output is forced to 0, including halt and illegal.
  - At the clock edge, state ← FETCH and the sticky flags clear.
- First cycle after rst deasserts: mem_req=1.
- Zero-wait latencies, fetch-to-retire inclusive:
  - BRANCH and FENCE: 3 cycles.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR, STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each extra mem_ready=0 cycle adds one cycle in FETCH or MEM. mem_req, mem_we and mem_addr_sel stay stable while waiting.
- mem_ready outside FETCH/MEM is ignored.
- rst during a pending request drops mem_req in the same cycle. No retire occurs.
- pc_we and retire always coincide, exactly once per instruction. Neither fires in HALT.

## Structure
- Package rv32_ctrl_pkg holds:
  - opcode constants
  - state enum
  - alu_op encodings: ADD=0000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, OR=0110, AND=0111, SUB=1000, SRA=1101, PASS_B=1111
  - pc_sel and wb_sel encodings
- One combinational sub-module, rv32_alu_op_dec, maps (opcode, func3, func7) to alu_op. The FSM is in the top module.

## Test plan
- ADD (opcode 01100, func3 000, func7 0), mem_ready always 1 → state sequence FETCH, DECODE, EXEC, WB; alu_op=0000, rf_we=1, wb_sel=0, retire at cycle 4.
- LW (00000/010) with mem_ready low for 2 cycles in MEM → mem_req held 3 cycles with mem_addr_sel=1, mem_we=0; WB wb_sel=1; retire at cycle 7.
- BEQ with branch_cond=1, then again with branch_cond=0 → each retires at cycle 3, with pc_sel=1 and then pc_sel=0; rf_we never asserts.
- JALR with func3=000 → WB: wb_sel=2, pc_sel=2. JALR with func3=001 → HALT with halt=1 and illegal=1, no retire.
- SRAI (00100/101, func7 1) → alu_op=1101. ECALL → halt=1, illegal=0, mem_req stays 0 thereafter.
- rst asserted while FETCH is waiting on mem_ready → all outputs 0 that cycle; after release, FETCH restarts with mem_req=1 and halt/illegal cleared.
